colour_mode_ctrl: RTL and testbench

//   Configuration controller for the colour_change pixel datapath. Debounces the four board

---
 rtl/colour_mode_ctrl.sv | 147 ++++++++++++++
 tb/tb_colour_mode_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_mode_ctrl.sv
// Button-driven colour-mode / bypass selector for the colour_change datapath.
// Presses are debounced and accumulated as a pending change that is committed on the next vsync rising edge.
module colour_mode_ctrl #(
  parameter int DB_CNT    = 250000,
  parameter int DB_W      = 18,
  parameter int NUM_MODES = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] btn,
  input  logic       i_vid_vsync,
  output logic [2:0] o_mode,
  output logic       o_bypass,
  output logic       o_update,
  output logic       o_pending
);

  typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

  logic [3:0] sync1_reg, sync2_reg;
  logic [3:0] level, level_q_reg;
  logic [3:0] press;
  logic       vsync_q_reg;
  logic       vs_rise;

  state_t     state_reg, state_next;
  logic [2:0] pm_reg, pm_next, pm_adj;
  logic       pb_reg, pb_next, pb_adj;
  logic [2:0] mode_reg;
  logic       bypass_reg;
  logic       update_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      level_q_reg <= '0;
      vsync_q_reg <= 1'b0;
    end else begin
      sync1_reg   <= btn;
      sync2_reg   <= sync1_reg;
      level_q_reg <= level;
      vsync_q_reg <= i_vid_vsync;
    end
  end

  // Level follows the synchronised input only after DB_CNT consecutive disagreeing cycles.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      logic [DB_W-1:0] cnt_reg;
      logic            lvl_reg;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          cnt_reg <= '0;
          lvl_reg <= 1'b0;
        end else if (sync2_reg[gi] == lvl_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_W'(DB_CNT - 1)) begin
          cnt_reg <= '0;
          lvl_reg <= sync2_reg[gi];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign level[gi] = lvl_reg;
    end
  endgenerate

  assign press   = level & ~level_q_reg;
  assign vs_rise = i_vid_vsync & ~vsync_q_reg;

  // Pending value with this cycle's presses applied; press[3] wins over everything.
  always_comb begin
    pm_adj = pm_reg;
    pb_adj = pb_reg;
    if (press[3]) begin
      pm_adj = 3'd0;
      pb_adj = 1'b0;
    end else begin
      if (press[0] && !press[1]) begin
        pm_adj = (pm_reg == 3'(NUM_MODES - 1)) ? 3'd0 : pm_reg + 3'd1;
      end else if (press[1] && !press[0]) begin
        pm_adj = (pm_reg == 3'd0) ? 3'(NUM_MODES - 1) : pm_reg - 3'd1;
      end
      if (press[2]) begin
        pb_adj = ~pb_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    pm_next    = pm_reg;
    pb_next    = pb_reg;
    case (state_reg)
      IDLE: begin
        if (|press) begin
          state_next = PENDING;
          pm_next    = pm_adj;
          pb_next    = pb_adj;
        end
      end
      PENDING: begin
        pm_next = pm_adj;
        pb_next = pb_adj;
        if (vs_rise) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        pm_next    = pm_adj;
        pb_next    = pb_adj;
        state_next = (|press) ? PENDING : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg  <= IDLE;
      pm_reg     <= 3'd0;
      pb_reg     <= 1'b0;
      mode_reg   <= 3'd0;
      bypass_reg <= 1'b0;
      update_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pm_reg     <= pm_next;
      pb_reg     <= pb_next;
      update_reg <= (state_reg == COMMIT);
      if (state_reg == COMMIT) begin
        mode_reg   <= pm_reg;
        bypass_reg <= pb_reg;
      end
    end
  end

  // o_update is registered so it is high in the same cycle the new values first appear.
  assign o_mode    = mode_reg;
  assign o_bypass  = bypass_reg;
  assign o_update  = update_reg;
  assign o_pending = (state_reg == PENDING);

endmodule

// File: tb/tb_colour_mode_ctrl.sv
// Self-checking bench for colour_mode_ctrl (DB_CNT=4, NUM_MODES=6).
// A behavioural model tracks pending and committed mode/bypass from the presses the bench applies.
module tb_colour_mode_ctrl;
  localparam int NM = 6;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       i_vid_vsync = 1'b0;
  logic [2:0] o_mode;
  logic       o_bypass, o_update, o_pending;

  int vectors = 0;
  int errors  = 0;
  int upd_count = 0;
  int m_commits = 0;

  int m_mode, p_mode;
  bit m_byp, p_byp, m_pend;

  colour_mode_ctrl #(.DB_CNT(4), .DB_W(8), .NUM_MODES(NM)) dut (
    .clk(clk), .n_rst(n_rst), .btn(btn), .i_vid_vsync(i_vid_vsync),
    .o_mode(o_mode), .o_bypass(o_bypass), .o_update(o_update), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_update === 1'b1) upd_count++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_mode = 0; m_byp = 0; p_mode = 0; p_byp = 0; m_pend = 0;
  endfunction

  function automatic void model_press(input logic [3:0] m);
    if (m == 4'd0) return;
    if (m[3]) begin
      p_mode = 0; p_byp = 0;
    end else begin
      if (m[0] && !m[1]) p_mode = (p_mode + 1) % NM;
      else if (m[1] && !m[0]) p_mode = (p_mode + NM - 1) % NM;
      if (m[2]) p_byp = !p_byp;
    end
    m_pend = 1;
  endfunction

  function automatic bit model_vsync();
    bit c;
    c = m_pend;
    if (m_pend) begin
      m_mode = p_mode; m_byp = p_byp; m_pend = 0; m_commits++;
    end
    return c;
  endfunction

  task automatic press(input logic [3:0] mask, input int hold);
    btn = mask;
    step(hold);
    btn = 4'd0;
    step(12);
    model_press(mask);
  endtask

  // Raises vsync and watches (bounded) for an o_update pulse; captures outputs on that cycle.
  task automatic frame(output bit got, output int obs_mode, output bit obs_byp);
    got = 0; obs_mode = -1; obs_byp = 0;
    i_vid_vsync = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (o_update === 1'b1) begin
        got = 1; obs_mode = int'(o_mode); obs_byp = o_bypass;
        break;
      end
    end
    step(3);
    i_vid_vsync = 1'b0;
    step(4);
  endtask

  task automatic check_frame(input string name);
    bit got, exp_got, ob;
    int om;
    exp_got = model_vsync();
    frame(got, om, ob);
    vectors++;
    if (got !== exp_got) begin
      errors++;
      $display("FAIL %s update: got %0d want %0d", name, got, exp_got);
    end
    vectors++;
    if (exp_got && (om !== m_mode || ob !== m_byp)) begin
      errors++;
      $display("FAIL %s commit: got mode=%0d byp=%0d want mode=%0d byp=%0d", name, om, ob, m_mode, m_byp);
    end
    vectors++;
    if (o_mode !== 3'(m_mode) || o_bypass !== m_byp || o_pending !== m_pend) begin
      errors++;
      $display("FAIL %s state: got mode=%0d byp=%0d pend=%0d want mode=%0d byp=%0d pend=%0d",
               name, o_mode, o_bypass, o_pending, m_mode, m_byp, m_pend);
    end
    $display("frame %s: update=%0d mode=%0d bypass=%0d", name, got, o_mode, o_bypass);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    model_reset();
    step(3);
    n_rst = 1'b1;
    step(2);
    vectors++;
    if (o_mode !== 3'd0 || o_bypass !== 1'b0 || o_update !== 1'b0 || o_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset: got mode=%0d byp=%0d upd=%0d pend=%0d want 0 0 0 0",
               o_mode, o_bypass, o_update, o_pending);
    end
    for (int i = 0; i < 3; i++) check_frame("idle_vsync");
    vectors++;
    if (upd_count !== 0) begin
      errors++;
      $display("FAIL idle_updates: got %0d want 0", upd_count);
    end
  endtask

  task automatic test_glitch_and_hold();
    btn = 4'b0001;
    step(3);
    btn = 4'b0000;
    step(12);
    vectors++;
    if (o_pending !== 1'b0) begin
      errors++;
      $display("FAIL glitch_pending: got %0d want 0", o_pending);
    end
    press(4'b0001, 20);
    vectors++;
    if (o_pending !== 1'b1) begin
      errors++;
      $display("FAIL hold_pending: got %0d want 1", o_pending);
    end
    check_frame("next_mode");
  endtask

  task automatic test_wrap();
    press(4'b1000, 12);
    for (int i = 0; i < 3; i++) press(4'b0010, 12);
    check_frame("prev_wrap");
  endtask

  task automatic test_bypass_combo();
    press(4'b0100, 12);
    press(4'b0011, 12);
    check_frame("bypass_combo");
  endtask

  task automatic test_override();
    press(4'b1000, 12);
    press(4'b0010, 12);
    press(4'b0010, 12);
    press(4'b0100, 12);
    check_frame("setup_4_1");
    press(4'b1001, 12);
    check_frame("override");
  endtask

  task automatic test_back_to_back();
    bit got, ob;
    int om;
    press(4'b1000, 12);
    check_frame("to_zero");
    press(4'b0001, 12);
    press(4'b0001, 12);
    // Raw press before edge N gives a press pulse in the cycle ending at edge N+6;
    // vsync is raised so its rising edge lands in that same cycle.
    btn = 4'b0001;
    step(6);
    model_press(4'b0001);
    void'(model_vsync());
    frame(got, om, ob);
    btn = 4'b0000;
    step(12);
    vectors++;
    if (got !== 1'b1 || om !== m_mode || ob !== m_byp) begin
      errors++;
      $display("FAIL coincident: got upd=%0d mode=%0d byp=%0d want upd=1 mode=%0d byp=%0d",
               got, om, ob, m_mode, m_byp);
    end
    vectors++;
    if (o_pending !== 1'b0) begin
      errors++;
      $display("FAIL coincident_pending: got %0d want 0", o_pending);
    end
    $display("frame coincident: update=%0d mode=%0d bypass=%0d", got, om, ob);

    press(4'b0001, 12);
    n_rst = 1'b0;
    step(1);
    n_rst = 1'b1;
    model_reset();
    step(2);
    vectors++;
    if (o_pending !== 1'b0 || o_mode !== 3'd0) begin
      errors++;
      $display("FAIL reset_pending: got pend=%0d mode=%0d want 0 0", o_pending, o_mode);
    end
    check_frame("after_reset");
  endtask

  task automatic test_random();
    logic [3:0] mask;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        btn = 4'($urandom_range(1, 15));
        step($urandom_range(1, 3));
        btn = 4'd0;
        step(12);
        vectors++;
        if (o_pending !== m_pend) begin
          errors++;
          $display("FAIL random_glitch: got pend=%0d want %0d", o_pending, m_pend);
        end
      end
      mask = 4'($urandom_range(1, 15));
      press(mask, $urandom_range(6, 14));
      vectors++;
      if (o_pending !== 1'b1) begin
        errors++;
        $display("FAIL random_press mask=%0h: got pend=%0d want 1", mask, o_pending);
      end
      if ($urandom_range(0, 1) == 1) check_frame("random");
    end
    check_frame("random_final");
    vectors++;
    if (upd_count !== m_commits) begin
      errors++;
      $display("FAIL update_count: got %0d want %0d", upd_count, m_commits);
    end
  endtask

  initial begin
    test_reset();
    test_glitch_and_hold();
    test_wrap();
    test_bypass_combo();
    test_override();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
